// File: rtl/subt_pkg.sv
// Shared widths and reset constants for the trial-subtract unit.
package subt_pkg;

    localparam int SUBT_A_W = 17;
    localparam int SUBT_B_W = 8;

    // Reset values correspond to the 0 - 0 result.
    localparam logic [SUBT_A_W-1:0] S_RST    = '0;
    localparam logic                COUT_RST = 1'b1;
    localparam logic                BO_RST   = 1'b0;
    localparam logic                EQZ_RST  = 1'b1;

endpackage

// File: rtl/subt_unit_if.sv
// Operand/result bundle for subt_unit.
// The slave side is the subtractor; the master side supplies operands.
interface subt_unit_if;
    import subt_pkg::*;

    logic [SUBT_A_W-1:0] A;
    logic [SUBT_B_W-1:0] B;
    logic [SUBT_A_W-1:0] S;
    logic                Cout;
    logic                Bo;
    logic                eqz;

    modport master (output A, output B, input S, input Cout, input Bo, input eqz);
    modport slave  (input A, input B, output S, output Cout, output Bo, output eqz);
endinterface

// File: rtl/subt_unit_full_adder.sv
// One-bit full-adder cell used to build the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/subt_unit.sv
// subt_unit: registered 17-bit minus 8-bit subtractor (A + ~B_ext + 1).
// Optional feature macro: SUBT_EQZ_EN enables the registered zero flag;
// without it eqz is tied to 0 and the zero-detect is not built.
module subt_unit
    import subt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    subt_unit_if.slave    bus
);

    logic [SUBT_A_W-1:0] b_inv;
    logic [SUBT_A_W-1:0] diff;
    logic [SUBT_A_W:0]   carry;

    logic [SUBT_A_W-1:0] s_reg;
    logic                cout_reg;
    logic                bo_reg;

    // Zero-extend B, then invert; the +1 of two's complement is the chain carry-in.
    assign b_inv    = ~{{(SUBT_A_W-SUBT_B_W){1'b0}}, bus.B};
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < SUBT_A_W; gi++) begin : g_chain
            full_adder u_fa (
                .a    (bus.A[gi]),
                .b    (b_inv[gi]),
                .cin  (carry[gi]),
                .s    (diff[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Output register: difference, carry-out and its complement borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg    <= S_RST;
            cout_reg <= COUT_RST;
            bo_reg   <= BO_RST;
        end else begin
            s_reg    <= diff;
            cout_reg <= carry[SUBT_A_W];
            bo_reg   <= ~carry[SUBT_A_W];
        end
    end

    assign bus.S    = s_reg;
    assign bus.Cout = cout_reg;
    assign bus.Bo   = bo_reg;

`ifdef SUBT_EQZ_EN
    logic eqz_reg;

    // Zero flag taken from the pre-register difference so it aligns with S.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eqz_reg <= EQZ_RST;
        end else begin
            eqz_reg <= (diff == '0);
        end
    end

    assign bus.eqz = eqz_reg;
`else
    assign bus.eqz = 1'b0;
`endif

endmodule

// File: tb/tb_subt_unit.sv
// Directed self-checking bench for subt_unit.
module tb_subt_unit;
    import subt_pkg::*;

`ifdef SUBT_EQZ_EN
    localparam logic EQZ_ON = 1'b1;
`else
    localparam logic EQZ_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    subt_unit_if bus ();

    subt_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] es, input logic ec,
                         input logic eb, input logic ez);
        logic ez_eff;
        ez_eff = ez & EQZ_ON;
        n_assert++;
        assert (bus.S === es) else begin
            n_fail++;
            $error("FAIL %s S got=%h exp=%h", tag, bus.S, es);
        end
        n_assert++;
        assert (bus.Cout === ec) else begin
            n_fail++;
            $error("FAIL %s Cout got=%b exp=%b", tag, bus.Cout, ec);
        end
        n_assert++;
        assert (bus.Bo === eb) else begin
            n_fail++;
            $error("FAIL %s Bo got=%b exp=%b", tag, bus.Bo, eb);
        end
        n_assert++;
        assert (bus.eqz === ez_eff) else begin
            n_fail++;
            $error("FAIL %s eqz got=%b exp=%b", tag, bus.eqz, ez_eff);
        end
        $display("%s: A=%h B=%h -> S=%h Cout=%b Bo=%b eqz=%b", tag, bus.A, bus.B,
                 bus.S, bus.Cout, bus.Bo, bus.eqz);
    endtask

    // Present operands, let one rising edge load them, sample 1 ns later.
    task automatic apply(input logic [16:0] a, input logic [7:0] b);
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.A    = '0;
        bus.B    = '0;

        // Load a real result before any reset so reset has something to clear.
        apply(17'd8, 8'd1);
        check("sub_8_1", 17'd7, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with A=5, B=3 present.
        bus.A = 17'd5;
        bus.B = 8'd3;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 17'd0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_hold1", 17'd0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_hold2", 17'd0, 1'b1, 1'b0, 1'b1);

        rst   = 1'b0;
        apply(17'd0, 8'd0);
        check("sub_0_0", 17'd0, 1'b1, 1'b0, 1'b1);

        apply(17'd8, 8'd1);
        check("sub_8_1b", 17'd7, 1'b1, 1'b0, 1'b0);

        apply(17'd0, 8'd1);
        check("wrap_0_1", 17'h1FFFF, 1'b0, 1'b1, 1'b0);

        apply(17'h1FFFF, 8'hFF);
        check("max_ff", 17'h1FF00, 1'b1, 1'b0, 1'b0);

        apply(17'h10000, 8'h80);
        check("msb_80", 17'h0FF80, 1'b1, 1'b0, 1'b0);

        // Back-to-back: equal operands then A one below B.
        apply(17'd200, 8'd200);
        check("eq_200", 17'd0, 1'b1, 1'b0, 1'b1);
        apply(17'd199, 8'd200);
        check("lt_199", 17'h1FFFF, 1'b0, 1'b1, 1'b0);

        apply(17'd255, 8'd255);
        check("eq_255", 17'd0, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
